// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache port arbiter: FSM encoding,
// datapath widths and latency-counter limits.
package dcache_pkg;

    localparam int DATA_W  = 32;
    localparam int TAG_W   = 5;
    localparam int CNT_W   = 4;
    localparam int LAT_MAX = 15;

    // Arbiter FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

endpackage

// File: rtl/dcache_lat_timer.sv
// Loadable 4-bit down-counter that times one cache access; Zero marks
// the completion cycle.
module dcache_lat_timer
    import dcache_pkg::*;
(
    input  logic             Clk,
    input  logic             Resetb,
    input  logic             Load,
    input  logic [CNT_W-1:0] LoadVal,
    input  logic             Dec,
    output logic             Zero
);

    logic [CNT_W-1:0] cnt;

    // Load on grant, otherwise count down while the access is in flight
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb)
            cnt <= '0;
        else if (Load)
            cnt <= LoadVal;
        else if (Dec)
            cnt <= cnt - 1'b1;
    end

    assign Zero = (cnt == '0);

endmodule

// File: rtl/dcache_port_arbiter.sv
// Arbitrates the single data-cache port between committed stores from the
// store buffer and loads from the LSQ, with a bounded load streak so stores
// cannot starve, and flush-kill of in-flight loads.
module dcache_port_arbiter
    import dcache_pkg::*;
#(
    parameter int WR_LAT        = 4,
    parameter int RD_LAT        = 3,
    parameter int LD_STREAK_MAX = 4
) (
    input  logic              Clk,
    input  logic              Resetb,
    input  logic              SB_DataValid,
    input  logic              SB_Full,
    input  logic [DATA_W-1:0] SB_AddrDmem,
    input  logic [DATA_W-1:0] SB_DataDmem,
    output logic              DCE_WriteDone,
    input  logic              Lsq_RdReq,
    input  logic [DATA_W-1:0] Lsq_RdAddr,
    input  logic [TAG_W-1:0]  Lsq_RdTag,
    output logic              Arb_RdGrant,
    output logic              Arb_RdDone,
    output logic [DATA_W-1:0] Arb_RdData,
    output logic [TAG_W-1:0]  Arb_RdTag,
    input  logic              Arb_Flush,
    output logic              Dc_En,
    output logic              Dc_We,
    output logic [DATA_W-1:0] Dc_Addr,
    output logic [DATA_W-1:0] Dc_WrData,
    input  logic [DATA_W-1:0] Dc_RdData
);

    localparam logic [CNT_W-1:0] WR_LD      = CNT_W'(WR_LAT - 1);
    localparam logic [CNT_W-1:0] RD_LD      = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(LD_STREAK_MAX);

    logic [1:0]        state, nState;
    logic              wrGo, rdGo, busy, tmrZero, opDone, kill;
    logic [CNT_W-1:0]  streak;
    logic [DATA_W-1:0] addrLat, dataLat;
    logic [TAG_W-1:0]  tagLat;

    assign busy   = (state != ST_IDLE);
    assign opDone = busy && tmrZero;

    // Port decision; only IDLE cycles may start an op, so every op is
    // followed by an IDLE cycle that sees the updated store-buffer head
    always_comb begin
        wrGo = 1'b0;
        rdGo = 1'b0;
        if (state == ST_IDLE) begin
            if (SB_DataValid && (SB_Full || streak == STREAK_MAX))
                wrGo = 1'b1;
            else if (Lsq_RdReq && !Arb_Flush)
                rdGo = 1'b1;
            else if (SB_DataValid)
                wrGo = 1'b1;
        end
    end

    // Next-state: start on grant, return to IDLE when the timer hits zero
    always_comb begin
        nState = state;
        if (state == ST_IDLE) begin
            if (wrGo)      nState = ST_WRITE;
            else if (rdGo) nState = ST_READ;
        end else if (tmrZero) begin
            nState = ST_IDLE;
        end
    end

    // State register
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) state <= ST_IDLE;
        else         state <= nState;
    end

    dcache_lat_timer u_timer (
        .Clk     (Clk),
        .Resetb  (Resetb),
        .Load    (wrGo | rdGo),
        .LoadVal (wrGo ? WR_LD : RD_LD),
        .Dec     (busy && !tmrZero),
        .Zero    (tmrZero)
    );

    // Capture the granted request so the cache sees stable operands
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            addrLat <= '0;
            dataLat <= '0;
            tagLat  <= '0;
        end else if (wrGo) begin
            addrLat <= SB_AddrDmem;
            dataLat <= SB_DataDmem;
        end else if (rdGo) begin
            addrLat <= Lsq_RdAddr;
            tagLat  <= Lsq_RdTag;
        end
    end

    // Load streak: bounds consecutive loads while a store is waiting
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb)
            streak <= '0;
        else if (!SB_DataValid || wrGo)
            streak <= '0;
        else if (rdGo && streak != STREAK_MAX)
            streak <= streak + 1'b1;
    end

    // Kill flag: a flushed load still occupies the port for its full latency
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb)
            kill <= 1'b0;
        else if (state == ST_READ) begin
            if (tmrZero)        kill <= 1'b0;
            else if (Arb_Flush) kill <= 1'b1;
        end
    end

    // Registered load return: data sampled in the completion cycle
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            Arb_RdDone <= 1'b0;
            Arb_RdData <= '0;
            Arb_RdTag  <= '0;
        end else begin
            Arb_RdDone <= 1'b0;
            if (state == ST_READ && tmrZero && !kill && !Arb_Flush) begin
                Arb_RdDone <= 1'b1;
                Arb_RdData <= Dc_RdData;
                Arb_RdTag  <= tagLat;
            end
        end
    end

    assign Arb_RdGrant   = rdGo;
    assign DCE_WriteDone = (state == ST_WRITE) && opDone;
    assign Dc_En         = busy;
    assign Dc_We         = (state == ST_WRITE);
    assign Dc_Addr       = busy ? addrLat : '0;
    assign Dc_WrData     = busy ? dataLat : '0;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter with default latencies
// (WR_LAT=4, RD_LAT=3, LD_STREAK_MAX=4). Inputs change 1ns after each
// rising edge, outputs are sampled 2ns after it.
module tb_dcache_port_arbiter;

    logic        Clk, Resetb;
    logic        SB_DataValid, SB_Full;
    logic [31:0] SB_AddrDmem, SB_DataDmem;
    logic        DCE_WriteDone;
    logic        Lsq_RdReq;
    logic [31:0] Lsq_RdAddr;
    logic [4:0]  Lsq_RdTag;
    logic        Arb_RdGrant, Arb_RdDone;
    logic [31:0] Arb_RdData;
    logic [4:0]  Arb_RdTag;
    logic        Arb_Flush;
    logic        Dc_En, Dc_We;
    logic [31:0] Dc_Addr, Dc_WrData, Dc_RdData;

    int total  = 0;
    int passed = 0;

    dcache_port_arbiter dut (
        .Clk(Clk), .Resetb(Resetb),
        .SB_DataValid(SB_DataValid), .SB_Full(SB_Full),
        .SB_AddrDmem(SB_AddrDmem), .SB_DataDmem(SB_DataDmem),
        .DCE_WriteDone(DCE_WriteDone),
        .Lsq_RdReq(Lsq_RdReq), .Lsq_RdAddr(Lsq_RdAddr), .Lsq_RdTag(Lsq_RdTag),
        .Arb_RdGrant(Arb_RdGrant), .Arb_RdDone(Arb_RdDone),
        .Arb_RdData(Arb_RdData), .Arb_RdTag(Arb_RdTag),
        .Arb_Flush(Arb_Flush),
        .Dc_En(Dc_En), .Dc_We(Dc_We), .Dc_Addr(Dc_Addr),
        .Dc_WrData(Dc_WrData), .Dc_RdData(Dc_RdData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to the next cycle; inputs may be driven right after this
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Resetb = 1'b0;
        SB_DataValid = 0; SB_Full = 0; SB_AddrDmem = 0; SB_DataDmem = 0;
        Lsq_RdReq = 0; Lsq_RdAddr = 0; Lsq_RdTag = 0;
        Arb_Flush = 0; Dc_RdData = 0;

        // Reset state
        #2;
        chk("rst_en", Dc_En, 0);
        chk("rst_we", Dc_We, 0);
        chk("rst_addr", Dc_Addr, 0);
        chk("rst_wdone", DCE_WriteDone, 0);
        chk("rst_rdone", Arb_RdDone, 0);
        chk("rst_grant", Arb_RdGrant, 0);
        cyc(); cyc();
        Resetb = 1'b1;
        cyc();

        // Lone store at T, followed by a second store that waits an IDLE cycle
        SB_DataValid = 1; SB_AddrDmem = 32'h100; SB_DataDmem = 32'hDEAD;
        #1 chk("st_T_en", Dc_En, 0);
        chk("st_T_grant", Arb_RdGrant, 0);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            if (k == 1) begin
                SB_AddrDmem = 32'h104; SB_DataDmem = 32'hBEE0;
            end
            #1;
            chk($sformatf("st_we_T%0d", k), Dc_We, 1);
            chk($sformatf("st_addr_T%0d", k), Dc_Addr, 32'h100);
            chk($sformatf("st_data_T%0d", k), Dc_WrData, 32'hDEAD);
            chk($sformatf("st_wdone_T%0d", k), DCE_WriteDone, (k == 4) ? 1 : 0);
        end
        cyc(); #1;
        chk("st_T5_idle", Dc_En, 0);
        chk("st_T5_wdone", DCE_WriteDone, 0);
        cyc(); #1;
        chk("st_T6_en", Dc_En, 1);
        chk("st_T6_addr", Dc_Addr, 32'h104);
        cyc(); cyc(); cyc(); #1;
        chk("st2_wdone", DCE_WriteDone, 1);
        cyc();
        SB_DataValid = 0;
        #1 chk("st2_idle", Dc_En, 0);

        // Lone load: grant at L, done with data/tag at L+4
        cyc();
        Lsq_RdReq = 1; Lsq_RdAddr = 32'h40; Lsq_RdTag = 5'd7;
        #1 chk("ld_grant", Arb_RdGrant, 1);
        cyc();
        Lsq_RdReq = 0; Dc_RdData = 32'h1234;
        #1 chk("ld_en", Dc_En, 1);
        chk("ld_we", Dc_We, 0);
        chk("ld_addr", Dc_Addr, 32'h40);
        cyc(); cyc(); #1;
        chk("ld_L3_done", Arb_RdDone, 0);
        cyc(); #1;
        chk("ld_L4_done", Arb_RdDone, 1);
        chk("ld_L4_data", Arb_RdData, 32'h1234);
        chk("ld_L4_tag", Arb_RdTag, 7);
        chk("ld_L4_idle", Dc_En, 0);
        cyc(); #1;
        chk("ld_L5_done", Arb_RdDone, 0);

        // Starvation: 4 read grants, then the store, then the streak restarts
        cyc();
        SB_DataValid = 1; SB_AddrDmem = 32'h180; SB_DataDmem = 32'h77;
        Lsq_RdReq = 1; Lsq_RdAddr = 32'h44; Lsq_RdTag = 5'd9;
        for (int k = 0; k <= 21; k++) begin
            if (k > 0) cyc();
            #1;
            chk($sformatf("stv_grant_%0d", k), Arb_RdGrant,
                ((k % 4 == 0 && k < 16) || k == 21) ? 1 : 0);
            chk($sformatf("stv_we_%0d", k), Dc_We, (k >= 17 && k <= 20) ? 1 : 0);
        end
        cyc();
        SB_DataValid = 0; Lsq_RdReq = 0;
        for (int k = 0; k < 4; k++) cyc();
        #1 chk("stv_settle", Dc_En, 0);

        // SB_Full overrides a pending load
        cyc();
        SB_DataValid = 1; SB_Full = 1; SB_AddrDmem = 32'h1C0;
        Lsq_RdReq = 1; Lsq_RdAddr = 32'h60; Lsq_RdTag = 5'd2;
        #1 chk("full_grant", Arb_RdGrant, 0);
        cyc(); #1;
        chk("full_we", Dc_We, 1);
        cyc(); cyc(); cyc(); #1;
        chk("full_wdone", DCE_WriteDone, 1);
        cyc();
        SB_DataValid = 0; SB_Full = 0; Dc_RdData = 32'hAAAA;
        #1 chk("full_then_rd", Arb_RdGrant, 1);

        // Flush at READ cycle 2: full latency, no done
        cyc();
        Lsq_RdReq = 0;
        cyc();
        Arb_Flush = 1;
        #1 chk("fl_en_c2", Dc_En, 1);
        cyc();
        Arb_Flush = 0;
        #1 chk("fl_en_c3", Dc_En, 1);
        cyc(); #1;
        chk("fl_idle", Dc_En, 0);
        chk("fl_nodone", Arb_RdDone, 0);
        cyc(); #1;
        chk("fl_nodone2", Arb_RdDone, 0);

        // Following load is delivered normally (kill flag cleared)
        Lsq_RdReq = 1; Lsq_RdAddr = 32'h80; Lsq_RdTag = 5'd3; Dc_RdData = 32'h5555;
        #1 chk("fl_next_grant", Arb_RdGrant, 1);
        cyc();
        Lsq_RdReq = 0;
        cyc(); cyc(); cyc(); #1;
        chk("fl_next_done", Arb_RdDone, 1);
        chk("fl_next_data", Arb_RdData, 32'h5555);
        chk("fl_next_tag", Arb_RdTag, 3);

        // Flush during WRITE has no effect
        cyc();
        SB_DataValid = 1; SB_AddrDmem = 32'h200; SB_DataDmem = 32'hBEEF;
        cyc(); cyc();
        Arb_Flush = 1;
        cyc(); #1;
        chk("flw_we", Dc_We, 1);
        cyc(); #1;
        chk("flw_wdone", DCE_WriteDone, 1);
        cyc();
        Arb_Flush = 0; SB_DataValid = 0;

        // Reset mid-WRITE
        cyc();
        SB_DataValid = 1; SB_AddrDmem = 32'h300; SB_DataDmem = 32'h33;
        cyc(); cyc();
        Resetb = 0; SB_DataValid = 0;
        #1;
        chk("rmw_en", Dc_En, 0);
        chk("rmw_we", Dc_We, 0);
        chk("rmw_addr", Dc_Addr, 0);
        chk("rmw_wdone", DCE_WriteDone, 0);
        cyc();
        Resetb = 1;
        for (int k = 0; k < 5; k++) begin
            cyc(); #1;
            chk($sformatf("rmw_post_wdone_%0d", k), DCE_WriteDone, 0);
            chk($sformatf("rmw_post_en_%0d", k), Dc_En, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
